// File: rtl/seg7_scan_driver_if.sv
// Display-side bundle for seg7_scan_driver: scan strobe, digit data/DP/enable in; anode, segment, DP and frame out.
// master = the logic that drives the data inputs; slave = the scan driver itself.
interface seg7_scan_driver_if #(
    parameter int NDIG = 8
);
    logic                CE;
    logic [4*NDIG-1:0]   DATA;
    logic [NDIG-1:0]     DP;
    logic [NDIG-1:0]     EN;
    logic [NDIG-1:0]     AN;
    logic [6:0]          SEG;
    logic                DP_N;
    logic                FRAME;

    modport master (
        output CE, DATA, DP, EN,
        input  AN, SEG, DP_N, FRAME
    );

    modport slave (
        input  CE, DATA, DP, EN,
        output AN, SEG, DP_N, FRAME
    );
endinterface

// File: rtl/seg7_scan_driver.sv
// Time-multiplexed common-anode 7-segment scan driver; one digit per CE strobe, inputs snapshotted once per frame.
// Optional leading-zero blanking is compiled in when the LZB_EN macro is defined.
module seg7_scan_driver #(
    parameter int NDIG = 8
) (
    input  logic                CLK,
    input  logic                RST,
    seg7_scan_driver_if.slave   bus
);
    localparam int                IDX_W    = $clog2(NDIG);
    localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(NDIG - 1);
    localparam logic [NDIG-1:0]   ONE_HOT0 = NDIG'(1);

    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [4*NDIG-1:0]  data_snap_q, data_snap_d;
    logic [NDIG-1:0]    dp_snap_q, dp_snap_d;
    logic [NDIG-1:0]    en_snap_q, en_snap_d;
    logic [NDIG-1:0]    an_q, an_d;
    logic [6:0]         seg_q, seg_d;
    logic               dp_n_q, dp_n_d;
    logic               frame_q, frame_d;
    logic               wrap;
    logic [NDIG-1:0]    visible;
    logic [3:0]         nib [NDIG];

    function automatic logic [6:0] hex7(input logic [3:0] v);
        logic [6:0] s;
        case (v)
            4'h0:    s = 7'b1000000;
            4'h1:    s = 7'b1111001;
            4'h2:    s = 7'b0100100;
            4'h3:    s = 7'b0110000;
            4'h4:    s = 7'b0011001;
            4'h5:    s = 7'b0010010;
            4'h6:    s = 7'b0000010;
            4'h7:    s = 7'b1111000;
            4'h8:    s = 7'b0000000;
            4'h9:    s = 7'b0010000;
            4'hA:    s = 7'b0001000;
            4'hB:    s = 7'b0000011;
            4'hC:    s = 7'b1000110;
            4'hD:    s = 7'b0100001;
            4'hE:    s = 7'b0000110;
            default: s = 7'b0001110;
        endcase
        return s;
    endfunction

    generate
        for (genvar gi = 0; gi < NDIG; gi++) begin : g_nib
            assign nib[gi] = data_snap_q[4*gi +: 4];
        end
    endgenerate

    // A new frame starts on the strobe that wraps the scan back to digit 0.
    assign wrap = bus.CE && (idx_q == LAST_IDX);

`ifdef LZB_EN
    logic [NDIG-1:0] blank_q, blank_d;
    logic [NDIG:1]   upper_zero;

    // upper_zero[k]: nibbles k..NDIG-1 of the incoming data are all zero; digit 0 is never blanked.
    assign upper_zero[NDIG] = 1'b1;
    generate
        for (genvar gi = 1; gi < NDIG; gi++) begin : g_lzb
            assign upper_zero[gi] = (bus.DATA[4*gi +: 4] == 4'h0) && upper_zero[gi+1];
        end
    endgenerate
    assign blank_d = wrap ? {upper_zero[NDIG-1:1], 1'b0} : blank_q;
    assign visible = en_snap_q & ~blank_q;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            blank_q <= '0;
        end else begin
            blank_q <= blank_d;
        end
    end
`else
    assign visible = en_snap_q;
`endif

    always_comb begin
        idx_d       = idx_q;
        data_snap_d = data_snap_q;
        dp_snap_d   = dp_snap_q;
        en_snap_d   = en_snap_q;
        frame_d     = wrap;
        if (bus.CE) begin
            idx_d = (idx_q == LAST_IDX) ? '0 : idx_q + 1'b1;
        end
        if (wrap) begin
            data_snap_d = bus.DATA;
            dp_snap_d   = bus.DP;
            en_snap_d   = bus.EN;
        end
    end

    // Output stage follows the registered index, so the display lags the strobe by one clock.
    always_comb begin
        an_d   = '1;
        seg_d  = 7'h7F;
        dp_n_d = 1'b1;
        if (visible[idx_q]) begin
            an_d   = ~(ONE_HOT0 << idx_q);
            seg_d  = hex7(nib[idx_q]);
            dp_n_d = ~dp_snap_q[idx_q];
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            idx_q       <= LAST_IDX;
            data_snap_q <= '0;
            dp_snap_q   <= '0;
            en_snap_q   <= '0;
            an_q        <= '1;
            seg_q       <= 7'h7F;
            dp_n_q      <= 1'b1;
            frame_q     <= 1'b0;
        end else begin
            idx_q       <= idx_d;
            data_snap_q <= data_snap_d;
            dp_snap_q   <= dp_snap_d;
            en_snap_q   <= en_snap_d;
            an_q        <= an_d;
            seg_q       <= seg_d;
            dp_n_q      <= dp_n_d;
            frame_q     <= frame_d;
        end
    end

    assign bus.AN    = an_q;
    assign bus.SEG   = seg_q;
    assign bus.DP_N  = dp_n_q;
    assign bus.FRAME = frame_q;
endmodule

// File: tb/tb_seg7_scan_driver.sv
// Directed bench for seg7_scan_driver (NDIG=8): reset, scan order, snapshot timing, enables, DP, CE held high, LZB_EN.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_seg7_scan_driver;
    logic CLK = 1'b0;
    logic RST;
    int   checks = 0;
    int   errors = 0;
    int   exp_idx;
    logic frame_obs;

    logic [6:0] hex_tab [16] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                                 7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                                 7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
                                 7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};

    always #5 CLK = ~CLK;

    seg7_scan_driver_if #(.NDIG(8)) bus ();

    seg7_scan_driver #(.NDIG(8)) dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One-cycle CE pulse; FRAME is captured the cycle after the strobe edge, outputs one cycle later.
    task automatic strobe();
        bus.CE = 1'b1;
        @(negedge CLK);
        frame_obs = bus.FRAME;
        bus.CE = 1'b0;
        exp_idx = (exp_idx == 7) ? 0 : exp_idx + 1;
        @(negedge CLK);
    endtask

    task automatic check_digit(input string tag, input int k, input logic lit,
                               input logic [3:0] nib, input logic dp);
        logic [7:0] an_e;
        logic [6:0] seg_e;
        logic       dpn_e;
        an_e  = lit ? ~(8'h01 << k) : 8'hFF;
        seg_e = lit ? hex_tab[nib] : 7'h7F;
        dpn_e = lit ? ~dp : 1'b1;
        check($sformatf("%s_d%0d_AN", tag, k), {24'h0, bus.AN}, {24'h0, an_e});
        check($sformatf("%s_d%0d_SEG", tag, k), {25'h0, bus.SEG}, {25'h0, seg_e});
        check($sformatf("%s_d%0d_DPN", tag, k), {31'h0, bus.DP_N}, {31'h0, dpn_e});
    endtask

    // Run to the end of the current frame, then step through a full frame of the given inputs.
    task automatic check_frame(input string tag, input logic [31:0] data, input logic [7:0] en,
                               input logic [7:0] dp, input logic [7:0] lit);
        bus.DATA = data;
        bus.EN   = en;
        bus.DP   = dp;
        while (exp_idx != 7) strobe();
        for (int k = 0; k < 8; k++) begin
            strobe();
            check($sformatf("%s_d%0d_FRAME", tag, k), {31'h0, frame_obs}, {31'h0, (k == 0)});
            check_digit(tag, k, lit[k], data[4*k +: 4], dp[k]);
        end
    endtask

    initial begin
        RST      = 1'b1;
        bus.CE   = 1'b0;
        bus.DATA = '0;
        bus.DP   = '0;
        bus.EN   = '0;
        exp_idx  = 7;
        repeat (3) @(negedge CLK);
        check("rst_AN", {24'h0, bus.AN}, 32'hFF);
        check("rst_SEG", {25'h0, bus.SEG}, 32'h7F);
        check("rst_DPN", {31'h0, bus.DP_N}, 32'h1);
        check("rst_FRAME", {31'h0, bus.FRAME}, 32'h0);
        RST = 1'b0;
        @(negedge CLK);
        check("idle_AN", {24'h0, bus.AN}, 32'hFF);

        // Basic scan
        bus.DATA = 32'h76543210;
        bus.EN   = 8'hFF;
        bus.DP   = 8'h00;
        strobe();
        check("t2_first_FRAME", {31'h0, frame_obs}, 32'h1);
        check("t2_first_AN", {24'h0, bus.AN}, 32'hFE);
        check("t2_first_SEG", {25'h0, bus.SEG}, {25'h0, 7'b1000000});
        repeat (8) @(negedge CLK);
        check("t2_hold_AN", {24'h0, bus.AN}, 32'hFE);
        check("t2_hold_FRAME", {31'h0, bus.FRAME}, 32'h0);
        strobe();
        check("t2_second_FRAME", {31'h0, frame_obs}, 32'h0);
        check("t2_second_AN", {24'h0, bus.AN}, 32'hFD);
        check("t2_second_SEG", {25'h0, bus.SEG}, {25'h0, 7'b1111001});
        for (int k = 2; k <= 4; k++) begin
            strobe();
            check_digit("t2", k, 1'b1, 4'(k), 1'b0);
        end

        // Mid-frame data change must not show until the wrap
        bus.DATA = 32'hFFFFFFFF;
        for (int k = 5; k <= 7; k++) begin
            strobe();
            check($sformatf("t3_old_d%0d_FRAME", k), {31'h0, frame_obs}, 32'h0);
            check_digit("t3_old", k, 1'b1, 4'(k), 1'b0);
        end
        strobe();
        check("t3_wrap_FRAME", {31'h0, frame_obs}, 32'h1);
        check("t3_wrap_SEG", {25'h0, bus.SEG}, {25'h0, 7'b0001110});
        check_digit("t3_new", 0, 1'b1, 4'hF, 1'b0);
        strobe();
        check_digit("t3_new", 1, 1'b1, 4'hF, 1'b0);
        strobe();
        strobe();
        check("t1_pre_AN", {24'h0, bus.AN}, 32'hF7);

        // Asynchronous reset mid-scan, away from any clock edge
        #2 RST = 1'b1;
        #1;
        check("t1_async_AN", {24'h0, bus.AN}, 32'hFF);
        check("t1_async_SEG", {25'h0, bus.SEG}, 32'h7F);
        check("t1_async_DPN", {31'h0, bus.DP_N}, 32'h1);
        @(negedge CLK);
        RST = 1'b0;
        exp_idx = 7;
        @(negedge CLK);
        strobe();
        check("t1_restart_FRAME", {31'h0, frame_obs}, 32'h1);
        check("t1_restart_AN", {24'h0, bus.AN}, 32'hFE);
        check("t1_restart_SEG", {25'h0, bus.SEG}, {25'h0, 7'b0001110});

        // Partial enable and a single decimal point
        check_frame("t4", 32'h76543210, 8'h0F, 8'h04, 8'h0F);

        // CE held high: one digit per clock, outputs one clock behind the index
        bus.CE = 1'b1;
        @(negedge CLK);
        check("t5_ce_wrap_FRAME", {31'h0, bus.FRAME}, 32'h1);
        for (int k = 0; k < 8; k++) begin
            @(negedge CLK);
            check($sformatf("t5_ce_d%0d_FRAME", k), {31'h0, bus.FRAME}, {31'h0, (k == 7)});
            check_digit("t5_ce", k, (k < 4), 4'(k), (k == 2));
        end
        bus.CE  = 1'b0;
        exp_idx = 0;

        // Leading zeros
`ifdef LZB_EN
        check_frame("t6a", 32'h00000A05, 8'hFF, 8'h00, 8'h07);
        check_frame("t6b", 32'h00000000, 8'hFF, 8'h00, 8'h01);
`else
        check_frame("t6a", 32'h00000A05, 8'hFF, 8'h00, 8'hFF);
        check_frame("t6b", 32'h00000000, 8'hFF, 8'h00, 8'hFF);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
